axi4_ddr_tester: RTL
====================

// Module: axi4_ddr_tester
// PURPOSE
//  AXI4 initiator that exercises the DDR memory slave (real controller or inferred model) end to end.
//  On start it fills a window with an address-derived pattern in INCR bursts, reads the window back and compares.
//  Sits on a spare master port of the system bus and is driven by the debug/APB side via start and status signals.
//  Reports pass/fail, error count and first failing address.
// PARAMETERS
//  BURST_LEN    8          max beats per AXI burst, 1..16, power of two
//  SEED         32'hA5C3   XOR key mixed into the data pattern
// PORTS
//  i_clk         in   1      single clock for all logic
//  i_rst         in   1      synchronous, active-high reset
//  i_start       in   1      1-cycle pulse; sampled only in IDLE/DONE
//  i_base_addr   in   48     window start, 8-byte aligned (bits[2:0] ignored)
//  i_len_words   in   24     window length in 64-bit words; 0 = empty test
//  o_busy        out  1      test in progress
//  o_done        out  1      held high from test end until next start
//  o_pass        out  1      valid when o_done: no mismatches, no bad responses
//  o_err_cnt     out  16     mismatching beats plus non-OKAY responses, saturates at 16'hFFFF
//  o_err_addr    out  48     address of first error; 0 if none
//  i_msti        in   axi4_master_in_type   AXI4 responses from the bus
//  o_msto        out  axi4_master_out_type  AXI4 requests to the bus
// BEHAVIOUR
//  Reset (i_rst=1 at clock edge): FSM->IDLE; all AXI valids, bready, rready = 0; o_busy=o_done=o_pass=0,
//   o_err_cnt=0, o_err_addr=0. Reset mid-burst abandons transaction; no outstanding state retained.
//  FSM: IDLE -start-> (len==0 ? DONE : WADDR) ; WADDR -awready-> WDATA ; WDATA -wready & wlast-> WRESP ;
//   WRESP -bvalid-> (words left ? WADDR : RADDR) ; RADDR -arready-> RDATA ;
//   RDATA -rvalid & rlast-> (words left ? RADDR : DONE) ; DONE -start-> WADDR or DONE(len 0).
//  Burst sizing: beats = min(BURST_LEN, words left, words to next 4 KB boundary); never crosses 4 KB.
//   awlen/arlen = beats-1, size = 3 (8 B), burst = INCR, id = 0, cache/prot/lock/qos/user = 0.
//  Handshake: valid raised in state entry cycle, held with stable payload until ready; AW completes before
//   first W beat (no overlap). wstrb = 8'hFF. wlast on beat beats-1. bready=1 only in WRESP, rready=1 only in RDATA.
//  One outstanding transaction at a time; throughput not a goal.
//  Pattern for word at byte address A: data = {A[31:0] ^ SEED, ~A[31:0]}; pure function of A.
//  Check: each rvalid&rready beat compares against pattern of its address; mismatch -> err_cnt+1.
//   bresp/rresp != OKAY -> err_cnt+1 (per response/beat; mismatch on same beat counts once).
//   First error latches o_err_addr (address of beat, or burst start for bresp); later errors do not overwrite.
//  o_pass = (err_cnt==0) registered on DONE entry; o_done and o_pass change same cycle, 1 cycle after last rlast.
//  Start while busy: ignored. Start in DONE: clears counters/err_addr/done/pass the next cycle.
//  Address arithmetic 48-bit, wrap at 2^48 allowed silently. Words-left counter 24-bit, no underflow.
// STRUCTURE
//  Shared package (types_ddr_tester_pkg): FSM state enum, pattern function ddr_tst_pattern(addr, seed),
//   beat-count function (4 KB clip). AXI types from types_amba_pkg.
//  Single module; no sub-module needed (pattern/clip are functions). Registered next-state style, one always_ff.
// TESTING (bench: this block + inferred DDR AXI4 SRAM model)
//  1 Reset mid-WDATA (beat 3 of 8) -> next cycle all valids 0, busy 0; new start runs clean to pass.
//  2 base=0x8000_0000, len=64, BURST_LEN=8 -> 8 AW + 8 AR bursts awlen=7; done, pass=1, err_cnt=0.
//  3 base=0x8000_0FE0, len=10 -> bursts of 4 then 6 beats (4 KB clip at 0x8000_1000); pass=1.
//  4 Model corrupts word at 0x8000_0018 after write -> err_cnt=1, err_addr=0x8000_0018, pass=0.
//  5 Model returns SLVERR on 2nd bresp, data intact -> err_cnt=1, err_addr=burst start, pass=0.
//  6 len=0 -> done high 1 cycle after start, pass=1, no AXI valid ever asserted; start while busy ignored.

Source files
------------

// File: rtl/types_amba_pkg.sv
// AXI4 system-bus types shared by bus masters and slaves.
package types_amba_pkg;

  localparam int CFG_SYSBUS_ADDR_BITS = 48;
  localparam int CFG_SYSBUS_DATA_BITS = 64;
  localparam int CFG_SYSBUS_ID_BITS   = 5;
  localparam int CFG_SYSBUS_USER_BITS = 1;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Requests from a master towards the interconnect.
  typedef struct packed {
    logic                            aw_valid;
    logic [CFG_SYSBUS_ADDR_BITS-1:0] aw_addr;
    logic [7:0]                      aw_len;
    logic [2:0]                      aw_size;
    logic [1:0]                      aw_burst;
    logic                            aw_lock;
    logic [3:0]                      aw_cache;
    logic [2:0]                      aw_prot;
    logic [3:0]                      aw_qos;
    logic [CFG_SYSBUS_ID_BITS-1:0]   aw_id;
    logic [CFG_SYSBUS_USER_BITS-1:0] aw_user;
    logic                            w_valid;
    logic [CFG_SYSBUS_DATA_BITS-1:0] w_data;
    logic                            w_last;
    logic [7:0]                      w_strb;
    logic [CFG_SYSBUS_USER_BITS-1:0] w_user;
    logic                            b_ready;
    logic                            ar_valid;
    logic [CFG_SYSBUS_ADDR_BITS-1:0] ar_addr;
    logic [7:0]                      ar_len;
    logic [2:0]                      ar_size;
    logic [1:0]                      ar_burst;
    logic                            ar_lock;
    logic [3:0]                      ar_cache;
    logic [2:0]                      ar_prot;
    logic [3:0]                      ar_qos;
    logic [CFG_SYSBUS_ID_BITS-1:0]   ar_id;
    logic [CFG_SYSBUS_USER_BITS-1:0] ar_user;
    logic                            r_ready;
  } axi4_master_out_type;

  // Responses from the interconnect back to a master.
  typedef struct packed {
    logic                            aw_ready;
    logic                            w_ready;
    logic                            b_valid;
    logic [1:0]                      b_resp;
    logic                            ar_ready;
    logic                            r_valid;
    logic [1:0]                      r_resp;
    logic [CFG_SYSBUS_DATA_BITS-1:0] r_data;
    logic                            r_last;
  } axi4_master_in_type;

endpackage

// File: rtl/types_ddr_tester_pkg.sv
// Shared definitions for the DDR end-to-end tester: FSM states, data pattern and burst sizing.
package types_ddr_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR,
    ST_WDATA,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA,
    ST_DONE
  } ddr_tst_state_t;

  // Expected contents of the 64-bit word at byte address addr (only the low 32 bits matter).
  function automatic logic [63:0] ddr_tst_pattern(input logic [31:0] addr, input logic [31:0] seed);
    return {addr ^ seed, ~addr};
  endfunction

  // Beats for the next burst: limited by burst length, remaining words and the next 4 KB page edge.
  // addr_idx is the 8-byte word index inside the 4 KB page (byte address bits [11:3]).
  function automatic logic [4:0] ddr_tst_beats(input logic [8:0] addr_idx, input logic [23:0] words_left,
                                               input int burst_len);
    logic [9:0]  to_4k;
    logic [23:0] n;
    to_4k = 10'd512 - {1'b0, addr_idx};
    n = 24'(burst_len);
    if (words_left < n) n = words_left;
    if ({14'd0, to_4k} < n) n = {14'd0, to_4k};
    return n[4:0];
  endfunction

endpackage

// File: rtl/axi4_ddr_tester.sv
// AXI4 initiator: writes an address-derived pattern over a window, reads it back and counts errors.
module axi4_ddr_tester
  import types_amba_pkg::*;
  import types_ddr_tester_pkg::*;
#(
  parameter int          BURST_LEN = 8,
  parameter logic [31:0] SEED      = 32'hA5C3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [47:0]         i_base_addr,
  input  logic [23:0]         i_len_words,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass,
  output logic [15:0]         o_err_cnt,
  output logic [47:0]         o_err_addr,
  input  axi4_master_in_type  i_msti,
  output axi4_master_out_type o_msto
);

  ddr_tst_state_t r_state, r_state_next;
  logic [47:0] r_base, r_base_next;
  logic [23:0] r_len, r_len_next;
  logic [47:0] r_burst_addr, r_burst_addr_next;
  logic [23:0] r_words_left, r_words_left_next;
  logic [4:0]  r_beat_cnt, r_beat_cnt_next;
  logic [15:0] r_err_cnt, r_err_cnt_next;
  logic [47:0] r_err_addr, r_err_addr_next;
  logic        r_done, r_done_next;
  logic        r_pass, r_pass_next;

  // Burst geometry is derived from registers that stay constant for the whole burst,
  // so AW/AR payload and wlast are stable without a separate beats register.
  logic [4:0]  w_beats;
  logic [23:0] w_words_rem;
  logic [47:0] w_burst_step;
  logic [47:0] w_beat_addr;
  logic        w_last_beat;
  logic        w_err_event;
  logic [47:0] w_err_loc;

  assign w_beats      = ddr_tst_beats(r_burst_addr[11:3], r_words_left, BURST_LEN);
  assign w_words_rem  = r_words_left - {19'd0, w_beats};
  assign w_burst_step = {40'd0, w_beats, 3'b000};
  assign w_beat_addr  = r_burst_addr + {40'd0, r_beat_cnt, 3'b000};
  assign w_last_beat  = (r_beat_cnt == (w_beats - 5'd1));

  // Error detection: bad write response counts at burst start, bad read beat (data or resp) counts once.
  always_comb begin
    w_err_event = 1'b0;
    w_err_loc   = w_beat_addr;
    if (r_state == ST_WRESP && i_msti.b_valid && i_msti.b_resp != AXI_RESP_OKAY) begin
      w_err_event = 1'b1;
      w_err_loc   = r_burst_addr;
    end else if (r_state == ST_RDATA && i_msti.r_valid &&
                 (i_msti.r_resp != AXI_RESP_OKAY ||
                  i_msti.r_data != ddr_tst_pattern(w_beat_addr[31:0], SEED))) begin
      w_err_event = 1'b1;
    end
  end

  // Next-state and datapath update for the write-then-read sequence.
  always_comb begin
    r_state_next      = r_state;
    r_base_next       = r_base;
    r_len_next        = r_len;
    r_burst_addr_next = r_burst_addr;
    r_words_left_next = r_words_left;
    r_beat_cnt_next   = r_beat_cnt;
    r_err_cnt_next    = r_err_cnt;
    r_err_addr_next   = r_err_addr;
    r_done_next       = r_done;
    r_pass_next       = r_pass;

    if (w_err_event) begin
      if (r_err_cnt != 16'hFFFF) r_err_cnt_next = r_err_cnt + 16'd1;
      if (r_err_cnt == 16'd0)    r_err_addr_next = w_err_loc;
    end

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          r_base_next       = i_base_addr & ~48'h7;
          r_len_next        = i_len_words;
          r_burst_addr_next = i_base_addr & ~48'h7;
          r_words_left_next = i_len_words;
          r_beat_cnt_next   = 5'd0;
          r_err_cnt_next    = 16'd0;
          r_err_addr_next   = 48'd0;
          if (i_len_words == 24'd0) begin
            r_state_next = ST_DONE;
            r_done_next  = 1'b1;
            r_pass_next  = 1'b1;
          end else begin
            r_state_next = ST_WADDR;
            r_done_next  = 1'b0;
            r_pass_next  = 1'b0;
          end
        end
      end
      ST_WADDR: begin
        if (i_msti.aw_ready) begin
          r_state_next    = ST_WDATA;
          r_beat_cnt_next = 5'd0;
        end
      end
      ST_WDATA: begin
        if (i_msti.w_ready) begin
          r_beat_cnt_next = r_beat_cnt + 5'd1;
          if (w_last_beat) r_state_next = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (i_msti.b_valid) begin
          if (w_words_rem != 24'd0) begin
            r_state_next      = ST_WADDR;
            r_burst_addr_next = r_burst_addr + w_burst_step;
            r_words_left_next = w_words_rem;
          end else begin
            r_state_next      = ST_RADDR;
            r_burst_addr_next = r_base;
            r_words_left_next = r_len;
          end
        end
      end
      ST_RADDR: begin
        if (i_msti.ar_ready) begin
          r_state_next    = ST_RDATA;
          r_beat_cnt_next = 5'd0;
        end
      end
      ST_RDATA: begin
        if (i_msti.r_valid) begin
          r_beat_cnt_next = r_beat_cnt + 5'd1;
          if (i_msti.r_last) begin
            r_burst_addr_next = r_burst_addr + w_burst_step;
            r_words_left_next = w_words_rem;
            if (w_words_rem != 24'd0) begin
              r_state_next = ST_RADDR;
            end else begin
              r_state_next = ST_DONE;
              r_done_next  = 1'b1;
              r_pass_next  = (r_err_cnt_next == 16'd0);
            end
          end
        end
      end
      default: r_state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_base       <= 48'd0;
      r_len        <= 24'd0;
      r_burst_addr <= 48'd0;
      r_words_left <= 24'd0;
      r_beat_cnt   <= 5'd0;
      r_err_cnt    <= 16'd0;
      r_err_addr   <= 48'd0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_state      <= r_state_next;
      r_base       <= r_base_next;
      r_len        <= r_len_next;
      r_burst_addr <= r_burst_addr_next;
      r_words_left <= r_words_left_next;
      r_beat_cnt   <= r_beat_cnt_next;
      r_err_cnt    <= r_err_cnt_next;
      r_err_addr   <= r_err_addr_next;
      r_done       <= r_done_next;
      r_pass       <= r_pass_next;
    end
  end

  // AXI request channels decoded from the registered state; unused sideband fields stay zero.
  always_comb begin
    o_msto          = '0;
    o_msto.aw_valid = (r_state == ST_WADDR);
    o_msto.aw_addr  = r_burst_addr;
    o_msto.aw_len   = 8'(w_beats - 5'd1);
    o_msto.aw_size  = 3'd3;
    o_msto.aw_burst = AXI_BURST_INCR;
    o_msto.w_valid  = (r_state == ST_WDATA);
    o_msto.w_data   = ddr_tst_pattern(w_beat_addr[31:0], SEED);
    o_msto.w_last   = w_last_beat;
    o_msto.w_strb   = 8'hFF;
    o_msto.b_ready  = (r_state == ST_WRESP);
    o_msto.ar_valid = (r_state == ST_RADDR);
    o_msto.ar_addr  = r_burst_addr;
    o_msto.ar_len   = 8'(w_beats - 5'd1);
    o_msto.ar_size  = 3'd3;
    o_msto.ar_burst = AXI_BURST_INCR;
    o_msto.r_ready  = (r_state == ST_RDATA);
  end

  assign o_busy     = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign o_done     = r_done;
  assign o_pass     = r_pass;
  assign o_err_cnt  = r_err_cnt;
  assign o_err_addr = r_err_addr;

endmodule
